// File: rtl/object_field_pkg.sv
// Shared types and default geometry for the falling-object playfield.
package object_field_pkg;

    localparam int COORD_W = 11;
    localparam int SCORE_W = 16;

    // Default screen and game geometry
    localparam int DEF_N_OBJ        = 4;
    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_OBJ_SIZE     = 16;
    localparam int DEF_PLAYER_Y     = 440;
    localparam int DEF_PLAYER_W     = 64;
    localparam int DEF_STEP         = 2;
    localparam int DEF_SPAWN_PERIOD = 60;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_wide_t;  // one guard bit so sums never wrap
    typedef logic [COORD_W+1:0] coord_sum_t;   // two guard bits for y + STEP + OBJ_SIZE

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SPAWN = 2'd2
    } state_e;

    // Fold a 10-bit random value into the legal spawn column range [0, limit).
    function automatic coord_t fold_spawn_x(input logic [9:0] raw, input int limit);
        coord_t raw_v;
        coord_t limit_v;
        raw_v   = {1'b0, raw};
        limit_v = coord_t'(limit);
        if (raw_v >= limit_v) begin
            return raw_v - limit_v;
        end else begin
            return raw_v;
        end
    endfunction

endpackage

// File: rtl/object_field_slot.sv
// Per-slot fall step plus catch/miss evaluation; shared by all slots in turn.
module object_slot_update
    import object_field_pkg::*;
#(
    parameter int V_RES    = DEF_V_RES,
    parameter int OBJ_SIZE = DEF_OBJ_SIZE,
    parameter int PLAYER_Y = DEF_PLAYER_Y,
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int STEP     = DEF_STEP
) (
    input  logic   slot_valid,
    input  coord_t slot_x,
    input  coord_t slot_y,
    input  coord_t player_x,
    output coord_t y_next,
    output logic   catch_hit,
    output logic   miss_hit
);

    coord_wide_t y_step_s;
    coord_sum_t  bottom_s;
    coord_wide_t obj_right_s;
    coord_wide_t pad_right_s;
    logic        reach_paddle_s;
    logic        overlap_s;
    logic        reach_floor_s;

    // Step the object down and classify it against paddle and floor; catch wins over miss.
    always_comb begin
        y_step_s       = {1'b0, slot_y} + coord_wide_t'(STEP);
        bottom_s       = {1'b0, y_step_s} + coord_sum_t'(OBJ_SIZE);
        obj_right_s    = {1'b0, slot_x} + coord_wide_t'(OBJ_SIZE);
        pad_right_s    = {1'b0, player_x} + coord_wide_t'(PLAYER_W);
        reach_paddle_s = (bottom_s >= coord_sum_t'(PLAYER_Y));
        overlap_s      = (obj_right_s > {1'b0, player_x}) && ({1'b0, slot_x} < pad_right_s);
        reach_floor_s  = (bottom_s >= coord_sum_t'(V_RES));
        y_next         = y_step_s[COORD_W-1:0];
        catch_hit      = slot_valid && reach_paddle_s && overlap_s;
        miss_hit       = slot_valid && !catch_hit && reach_floor_s;
    end

endmodule

// File: rtl/object_field.sv
// Falling-object playfield: once per frame, step every live slot, score
// catches and misses, and periodically spawn a new object.
module object_field
    import object_field_pkg::*;
#(
    parameter int N_OBJ        = DEF_N_OBJ,
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int OBJ_SIZE     = DEF_OBJ_SIZE,
    parameter int PLAYER_Y     = DEF_PLAYER_Y,
    parameter int PLAYER_W     = DEF_PLAYER_W,
    parameter int STEP         = DEF_STEP,
    parameter int SPAWN_PERIOD = DEF_SPAWN_PERIOD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [COORD_W-1:0]       random_number,
    input  logic [COORD_W-1:0]       player_x,
    output logic [N_OBJ-1:0]         obj_valid,
    output logic [COORD_W*N_OBJ-1:0] obj_x,
    output logic [COORD_W*N_OBJ-1:0] obj_y,
    output logic                     catch_pulse,
    output logic                     miss_pulse,
    output logic [SCORE_W-1:0]       score,
    output logic                     busy
);

    localparam int IDX_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int CNT_W       = ($clog2(SPAWN_PERIOD) > 0) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int SPAWN_RANGE = H_RES - OBJ_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

    state_e             state_r;
    state_e             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               pending_r;
    logic [CNT_W-1:0]   frame_cnt_r;
    logic [N_OBJ-1:0]   obj_valid_r;
    coord_t             obj_x_r [N_OBJ];
    coord_t             obj_y_r [N_OBJ];
    logic               catch_r;
    logic               miss_r;
    logic [SCORE_W-1:0] score_r;
    logic               busy_r;

    logic               cur_valid_s;
    coord_t             cur_x_s;
    coord_t             cur_y_s;
    coord_t             upd_y_s;
    logic               upd_catch_s;
    logic               upd_miss_s;
    logic               free_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    coord_t             spawn_x_s;
    logic               unused_rand_s;

    // Only the low ten random bits pick the spawn column.
    assign unused_rand_s = random_number[COORD_W-1];

    // Present the slot currently being scanned to the shared update logic.
    always_comb begin
        cur_valid_s = obj_valid_r[idx_r];
        cur_x_s     = obj_x_r[idx_r];
        cur_y_s     = obj_y_r[idx_r];
    end

    object_slot_update #(
        .V_RES    (V_RES),
        .OBJ_SIZE (OBJ_SIZE),
        .PLAYER_Y (PLAYER_Y),
        .PLAYER_W (PLAYER_W),
        .STEP     (STEP)
    ) u_slot_update (
        .slot_valid (cur_valid_s),
        .slot_x     (cur_x_s),
        .slot_y     (cur_y_s),
        .player_x   (player_x),
        .y_next     (upd_y_s),
        .catch_hit  (upd_catch_s),
        .miss_hit   (upd_miss_s)
    );

    // Find the lowest-index free slot; scanning downward lets the lowest one win.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (!obj_valid_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_idx_s   = free_idx_s;
            end
        end
        spawn_x_s = fold_spawn_x(random_number[9:0], SPAWN_RANGE);
    end

    // Next-state logic: IDLE -> SCAN (one slot per cycle) -> SPAWN -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick || pending_r) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = ST_SPAWN;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_SPAWN: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM, slot storage, pulses, score and spawn counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            pending_r   <= 1'b0;
            frame_cnt_r <= '0;
            obj_valid_r <= '0;
            catch_r     <= 1'b0;
            miss_r      <= 1'b0;
            score_r     <= '0;
            busy_r      <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                obj_x_r[i] <= '0;
                obj_y_r[i] <= '0;
            end
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            catch_r <= 1'b0;
            miss_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idx_r     <= '0;
                    pending_r <= 1'b0;
                end
                ST_SCAN: begin
                    if (frame_tick) begin
                        pending_r <= 1'b1;
                    end
                    idx_r <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
                    if (upd_catch_s) begin
                        obj_valid_r[idx_r] <= 1'b0;
                        catch_r            <= 1'b1;
                        score_r            <= (score_r == 16'hFFFF) ? score_r : score_r + 16'd1;
                    end else if (upd_miss_s) begin
                        obj_valid_r[idx_r] <= 1'b0;
                        miss_r             <= 1'b1;
                    end else if (cur_valid_s) begin
                        obj_y_r[idx_r] <= upd_y_s;
                    end
                end
                ST_SPAWN: begin
                    if (frame_tick) begin
                        pending_r <= 1'b1;
                    end
                    if ((frame_cnt_r == '0) && free_found_s) begin
                        obj_valid_r[free_idx_s] <= 1'b1;
                        obj_x_r[free_idx_s]     <= spawn_x_s;
                        obj_y_r[free_idx_s]     <= '0;
                    end
                    frame_cnt_r <= (frame_cnt_r == CNT_LAST) ? '0 : frame_cnt_r + CNT_W'(1);
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign obj_valid   = obj_valid_r;
    assign catch_pulse = catch_r;
    assign miss_pulse  = miss_r;
    assign score       = score_r;
    assign busy        = busy_r;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
        assign obj_x[g*COORD_W +: COORD_W] = obj_x_r[g];
        assign obj_y[g*COORD_W +: COORD_W] = obj_y_r[g];
    end

endmodule

// File: tb/tb_object_field.sv
// Directed bench for object_field: a scoreboard queue holds expected
// catch/miss events with the score that must accompany them.
module tb_object_field;
    import object_field_pkg::*;

    localparam int N = 4;
    localparam int W = COORD_W;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           frame_tick = 1'b0;
    logic [W-1:0]   random_number = '0;
    logic [W-1:0]   player_x = '0;
    logic [N-1:0]   obj_valid;
    logic [W*N-1:0] obj_x;
    logic [W*N-1:0] obj_y;
    logic           catch_pulse;
    logic           miss_pulse;
    logic [15:0]    score;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        is_catch;
        logic [15:0] score;
    } exp_t;
    exp_t exp_q[$];

    always #20 clk = ~clk;

    object_field #(
        .N_OBJ        (N),
        .SPAWN_PERIOD (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .random_number (random_number),
        .player_x      (player_x),
        .obj_valid     (obj_valid),
        .obj_x         (obj_x),
        .obj_y         (obj_y),
        .catch_pulse   (catch_pulse),
        .miss_pulse    (miss_pulse),
        .score         (score),
        .busy          (busy)
    );

    function automatic logic [W-1:0] get_x(input int k);
        return obj_x[k*W +: W];
    endfunction

    function automatic logic [W-1:0] get_y(input int k);
        return obj_y[k*W +: W];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_catch, input logic [15:0] sc);
        exp_t e;
        e.is_catch = is_catch;
        e.score    = sc;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        frame_tick = 1'b0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One frame: single-cycle tick, then wait (bounded) for the pass to finish.
    task automatic do_frame(output int busy_cycles);
        bit done;
        busy_cycles = 0;
        done        = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) begin
                busy_cycles++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: busy still %0b after 40 cycles, required 0", busy);
        end
    endtask

    initial begin
        int bc;
        int passes;
        logic prev;

        // Scoreboard monitor: every pulse must match the head of the queue.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (catch_pulse || miss_pulse) begin
                        n_checks++;
                        if (catch_pulse && miss_pulse) begin
                            n_fail++;
                            $display("FAIL pulse_both: catch=1 miss=1, required one at a time");
                        end else if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pulse: catch=%0b miss=%0b score=%0d, required no pulse",
                                     catch_pulse, miss_pulse, score);
                        end else begin
                            e = exp_q.pop_front();
                            if (catch_pulse !== e.is_catch || score !== e.score) begin
                                n_fail++;
                                $display("FAIL pulse_event: catch=%0b score=%0d, required catch=%0b score=%0d",
                                         catch_pulse, score, e.is_catch, e.score);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(obj_valid), 32'd0);
        check("rst_x_zero", 32'(obj_x == '0), 32'd1);
        check("rst_y_zero", 32'(obj_y == '0), 32'd1);
        check("rst_score", 32'(score), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({catch_pulse, miss_pulse}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // First frame after reset spawns with folded column 700 -> 76
        random_number = 11'd700;
        player_x      = 11'd290;
        do_frame(bc);
        check("a_busy_cycles", 32'(bc), 32'd5);
        check("a_valid", 32'(obj_valid), 32'd1);
        check("a_x0", 32'(get_x(0)), 32'd76);
        check("a_y0", 32'(get_y(0)), 32'd0);
        check("a_busy_low", 32'(busy), 32'd0);

        // Two ticks while busy give exactly one extra pass
        apply_reset();
        random_number = 11'd100;
        passes = 0;
        prev   = 1'b0;
        for (int s = 0; s < 40; s++) begin
            frame_tick = (s == 0 || s == 2 || s == 4);
            @(negedge clk);
            if (busy && !prev) passes++;
            prev = busy;
        end
        frame_tick = 1'b0;
        check("b_passes", 32'(passes), 32'd2);
        check("b_valid", 32'(obj_valid), 32'd3);
        check("b_y0", 32'(get_y(0)), 32'd2);
        check("b_x1", 32'(get_x(1)), 32'd100);
        check("b_y1", 32'(get_y(1)), 32'd0);

        // Long run: fill, catch, respawn, miss, catch-over-miss priority
        apply_reset();
        player_x      = 11'd290;
        random_number = 11'd300;
        do_frame(bc);
        check("l_valid_p1", 32'(obj_valid), 32'd1);
        check("l_x0_p1", 32'(get_x(0)), 32'd300);
        random_number = 11'd500;
        for (int p = 2; p <= 235; p++) begin
            player_x = (p <= 213) ? 11'd290 : ((p == 235) ? 11'd480 : 11'd0);
            if (p == 213) push_exp(1'b1, 16'd1);
            if (p == 234) push_exp(1'b0, 16'd1);
            if (p == 235) begin
                push_exp(1'b1, 16'd2);
                push_exp(1'b1, 16'd3);
            end
            do_frame(bc);
            if (p == 4) check("l_full_p4", 32'(obj_valid), 32'd15);
            if (p == 10) begin
                check("l_full_p10", 32'(obj_valid), 32'd15);
                check("l_y0_p10", 32'(get_y(0)), 32'd18);
                check("l_y3_p10", 32'(get_y(3)), 32'd12);
            end
            if (p == 212) begin
                check("l_y0_p212", 32'(get_y(0)), 32'd422);
                check("l_score_p212", 32'(score), 32'd0);
            end
            if (p == 213) begin
                check("l_valid_p213", 32'(obj_valid), 32'd15);
                check("l_x0_p213", 32'(get_x(0)), 32'd500);
                check("l_y0_p213", 32'(get_y(0)), 32'd0);
                check("l_score_p213", 32'(score), 32'd1);
            end
            if (p == 234) begin
                check("l_valid_p234", 32'(obj_valid), 32'd15);
                check("l_y1_p234", 32'(get_y(1)), 32'd0);
                check("l_score_p234", 32'(score), 32'd1);
            end
            if (p == 235) begin
                check("l_valid_p235", 32'(obj_valid), 32'd7);
                check("l_x2_p235", 32'(get_x(2)), 32'd500);
                check("l_y2_p235", 32'(get_y(2)), 32'd0);
                check("l_score_p235", 32'(score), 32'd3);
            end
        end
        repeat (3) @(negedge clk);
        check("l_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the pass that would catch slot 0
        apply_reset();
        player_x      = 11'd290;
        random_number = 11'd300;
        for (int p = 1; p <= 212; p++) begin
            do_frame(bc);
        end
        check("r_y0_p212", 32'(get_y(0)), 32'd422);
        check("r_valid_p212", 32'(obj_valid), 32'd15);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        rst        = 1'b0;
        #1;
        check("r_valid_zero", 32'(obj_valid), 32'd0);
        check("r_x_zero", 32'(obj_x == '0), 32'd1);
        check("r_y_zero", 32'(obj_y == '0), 32'd1);
        check("r_score_zero", 32'(score), 32'd0);
        check("r_busy_zero", 32'(busy), 32'd0);
        check("r_pulses_zero", 32'({catch_pulse, miss_pulse}), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        random_number = 11'd700;
        do_frame(bc);
        check("r_valid_after", 32'(obj_valid), 32'd1);
        check("r_x0_after", 32'(get_x(0)), 32'd76);
        check("r_score_after", 32'(score), 32'd0);
        repeat (3) @(negedge clk);
        check("r_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "global timeout");
    end

endmodule
